// File: rtl/div_iterative_pkg.sv
// Shared constants and state encoding for the iterative signed divider.
package div_iterative_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MIN_INT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_iterative_negate.sv
// Two's-complement negation: bitwise invert plus one.
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = ~a_i + WIDTH'(1);

endmodule

// File: rtl/div_iterative.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per clock, with the quotient sign applied in a final cycle.
module div_iterative
    import div_iterative_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] neg_a, neg_b, neg_q;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, trial;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (.a_i(data_operandA), .y_o(neg_a));
    twos_negate #(.WIDTH(WIDTH)) u_neg_b (.a_i(data_operandB), .y_o(neg_b));
    twos_negate #(.WIDTH(WIDTH)) u_neg_q (.a_i(quo_q),         .y_o(neg_q));

    // Magnitudes are unsigned, so -2^(WIDTH-1) negates to its exact magnitude.
    assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

    // Shifted remainder is below 2^WIDTH, so the top bit of trial is its sign.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start in any state (re)launches; an aborted run never reaches DONE.
        if (ctrl_DIV) begin
            quo_d  = abs_a;
            div_d  = abs_b;
            rem_d  = '0;
            sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            cnt_d  = CNT_W'(WIDTH);
            ovf_d  = (data_operandA == MIN_VAL) && (data_operandB == '1);
            if (data_operandB == '0) begin
                zero_d   = 1'b1;
                result_d = '0;
                exc_d    = 1'b1;
                state_d  = FIX;
            end else begin
                zero_d  = 1'b0;
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (!zero_q) begin
                        result_d = sign_q ? neg_q : quo_q;
                        exc_d    = ovf_q;
                    end
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_iterative.sv
// Randomized and directed bench for div_iterative against a signed-division model.
module tb_div_iterative;
    import div_iterative_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;

    int checks   = 0;
    int failures = 0;

    div_iterative #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (a_in),
        .data_operandB  (b_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Reference: truncated signed division with the two exception cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic e);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '0;
            e = 1'b1;
        end else if (a == MIN_INT && b == {W{1'b1}}) begin
            q = MIN_INT;
            e = 1'b1;
        end else begin
            q = W'(sa / sb);
            e = 1'b0;
        end
    endtask

    // Leaves the bench at the falling edge of the cycle right after the start edge.
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_DIV = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
    endtask

    task automatic watch(input int cycles, output int first_idx, output int pulses,
                         output logic [W-1:0] res, output logic exc);
        first_idx = -1;
        pulses    = 0;
        res       = 'x;
        exc       = 1'bx;
        for (int i = 0; i < cycles; i++) begin
            if (data_resultRDY === 1'b1) begin
                if (pulses == 0) begin
                    first_idx = i;
                    res       = data_result;
                    exc       = data_exception;
                end
                pulses++;
            end
            @(negedge clock);
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int first_idx, pulses, exp_lat;
        logic [W-1:0] res, exp_q;
        logic exc, exp_e;
        model(a, b, exp_q, exp_e);
        exp_lat = (b == '0) ? 1 : 33;
        start_div(a, b);
        watch(45, first_idx, pulses, res, exc);
        checks++;
        if (res !== exp_q) begin
            failures++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h)", name, res, exp_q, a, b);
        end
        checks++;
        if (exc !== exp_e) begin
            failures++;
            $display("FAIL %s exception: got %b expected %b (a=%h b=%h)", name, exc, exp_e, a, b);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL %s rdy_pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (first_idx !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, first_idx, exp_lat);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset    = 1'b1;
        ctrl_DIV = 1'b1;
        a_in     = 32'd5;
        b_in     = '0;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        checks++;
        if (data_result !== '0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b expected 0/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0 || data_exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_wins_over_start: got rdy=%b exc=%b expected 0/0",
                     data_resultRDY, data_exception);
        end
    endtask

    task automatic test_directed();
        run_check("pos_pos",   32'd100,        32'd7);
        run_check("neg_pos",   -32'sd100,      32'd7);
        run_check("pos_neg",   32'd100,        -32'sd7);
        run_check("neg_neg",   -32'sd100,      -32'sd7);
        run_check("small_num", 32'd7,          32'd100);
        run_check("div_zero",  32'd123,        32'd0);
        run_check("overflow",  32'h8000_0000,  32'hFFFF_FFFF);
        run_check("min_by_1",  32'h8000_0000,  32'd1);
        run_check("min_by_m2", 32'h8000_0000,  32'hFFFF_FFFE);
        run_check("max_by_1",  32'h7FFF_FFFF,  32'd1);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(1, 20));
                1: b = -W'($urandom_range(1, 20));
                2: b = (n % 7 == 0) ? '0 : W'($urandom_range(1, 1000));
                default: b = $urandom;
            endcase
            run_check("random", a, b);
        end
    endtask

    task automatic test_hold();
        run_check("hold_setup", -32'sd100, 32'd7);
        repeat (5) @(negedge clock);
        checks++;
        if (data_result !== 32'hFFFF_FFF2 || data_exception !== 1'b0) begin
            failures++;
            $display("FAIL hold_result: got %h/%b expected fffffff2/0", data_result, data_exception);
        end
    endtask

    task automatic test_back_to_back();
        int first_idx, pulses;
        logic [W-1:0] res;
        logic exc;
        start_div(32'd100, 32'd7);
        watch(10, first_idx, pulses, res, exc);
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL restart_early_pulse: got %0d expected 0", pulses);
        end
        ctrl_DIV = 1'b1;
        a_in     = 32'd50;
        b_in     = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        watch(45, first_idx, pulses, res, exc);
        checks++;
        if (pulses !== 1 || first_idx !== 33) begin
            failures++;
            $display("FAIL restart_pulse: got pulses=%0d at %0d expected 1 at 33", pulses, first_idx);
        end
        checks++;
        if (res !== 32'd10 || exc !== 1'b0) begin
            failures++;
            $display("FAIL restart_result: got %h/%b expected 0000000a/0", res, exc);
        end
    endtask

    task automatic test_reset_mid();
        int first_idx, pulses;
        logic [W-1:0] res;
        logic exc;
        start_div(32'd100, 32'd7);
        watch(15, first_idx, pulses, res, exc);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (data_result !== '0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset_outputs: got res=%h exc=%b rdy=%b expected 0/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        watch(45, first_idx, pulses, res, exc);
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midrun_reset_no_pulse: got %0d expected 0", pulses);
        end
        run_check("after_reset", 32'd9, 32'd3);
    endtask

    initial begin
        reset    = 1'b1;
        ctrl_DIV = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
